iq_decim_acc: RTL and testbench

- Downstream consumer of the complex single-pole low-pass filter output: interleaved I/Q, 20-bit signed, one sample per clock.
- Boxcar-accumulates N complex pairs, then applies a programmable arithmetic right shift and saturation.
- Presents de-interleaved I and Q words with a one-cycle strobe, for host readout or a slower-rate downstream stage.
- Provides decimation plus extra averaging of the filtered baseband.

---
 rtl/iq_acc_lane.sv | 85 ++++++++
 rtl/iq_decim_acc.sv | 127 ++++++++++++
 tb/tb_iq_decim_acc.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/iq_acc_lane.sv
// iq_acc_lane: one boxcar accumulator lane of the I/Q decimator.
// Loads or adds a sign-extended sample into an aw-bit accumulator, and on
// capture registers the arithmetically right-shifted, saturated result.
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   i_load   replace accumulator with sext(i_din)
//   i_add    add sext(i_din) to accumulator
//   i_clr    clear accumulator (lowest priority)
//   i_cap    register shifted/saturated accumulator result on o_word/o_sat
//   i_shift  arithmetic right shift 0..15
//   i_din    signed input sample
//   o_word   signed saturated output word (held between captures)
//   o_sat    1 for the cycle after a capture that clipped
module iq_acc_lane #(
    parameter int dw = 20,
    parameter int ow = 22,
    parameter int aw = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_add,
    input  logic                 i_clr,
    input  logic                 i_cap,
    input  logic [3:0]           i_shift,
    input  logic signed [dw-1:0] i_din,
    output logic signed [ow-1:0] o_word,
    output logic                 o_sat
);

    localparam logic signed [aw-1:0] C_MAX = {{(aw-ow+1){1'b0}}, {(ow-1){1'b1}}};
    localparam logic signed [aw-1:0] C_MIN = {{(aw-ow+1){1'b1}}, {(ow-1){1'b0}}};

    // MSB of the result flags a clip; low ow bits are the output word.
    function automatic logic [ow:0] f_sat(input logic signed [aw-1:0] v);
        if (v > C_MAX)
            return {1'b1, C_MAX[ow-1:0]};
        else if (v < C_MIN)
            return {1'b1, C_MIN[ow-1:0]};
        else
            return {1'b0, v[ow-1:0]};
    endfunction

    logic signed [aw-1:0] r_acc;
    logic signed [ow-1:0] r_word;
    logic                 r_sat;
    logic signed [aw-1:0] w_sext;
    logic signed [aw-1:0] w_next;
    logic signed [aw-1:0] w_shifted;
    logic [ow:0]          w_sat_word;

    assign w_sext = {{(aw-dw){i_din[dw-1]}}, i_din};

    always_comb begin
        w_next = r_acc;
        if (i_load)
            w_next = w_sext;
        else if (i_add)
            w_next = r_acc + w_sext;
        else if (i_clr)
            w_next = '0;
    end

    // Capture uses the post-update value so the sample arriving on the
    // completing cycle is included.
    assign w_shifted  = w_next >>> i_shift;
    assign w_sat_word = f_sat(w_shifted);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_word <= '0;
            r_sat  <= 1'b0;
        end else begin
            r_acc <= w_next;
            r_sat <= i_cap & w_sat_word[ow];
            if (i_cap)
                r_word <= w_sat_word[ow-1:0];
        end
    end

    assign o_word = r_word;
    assign o_sat  = r_sat;

endmodule

// File: rtl/iq_decim_acc.sv
// iq_decim_acc: decimating boxcar averager for interleaved I/Q samples.
// Accumulates N complex pairs (I cycle then Q cycle), then presents the
// shifted and saturated I and Q sums with a one-cycle strobe.
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   iq      1 = I sample on din, 0 = Q sample
//   din     signed interleaved sample
//   decim   pairs per output N (0 treated as 1), latched at window open
//   shift   arithmetic right shift, latched at window open
//   i_out   signed decimated I (held between strobes)
//   q_out   signed decimated Q (held between strobes)
//   strobe  one-cycle pulse when i_out/q_out update
//   sat     1 with strobe if either output clipped
//   err     sticky framing error (iq repeated inside a window)
module iq_decim_acc #(
    parameter int dw = 20,
    parameter int ow = 22,
    parameter int nw = 8,
    parameter int aw = dw + nw
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iq,
    input  logic signed [dw-1:0] din,
    input  logic [nw-1:0]        decim,
    input  logic [3:0]           shift,
    output logic signed [ow-1:0] i_out,
    output logic signed [ow-1:0] q_out,
    output logic                 strobe,
    output logic                 sat,
    output logic                 err
);

    logic          r_active;
    logic          r_prev_iq;
    logic [nw-1:0] r_cnt;
    logic [nw-1:0] r_n;
    logic [3:0]    r_shift;
    logic          r_strobe;
    logic          r_err;

    logic w_proto_err;
    logic w_open;
    logic w_i_add;
    logic w_q_step;
    logic w_q_load;
    logic w_q_add;
    logic w_last;
    logic w_done;
    logic w_sat_i;
    logic w_sat_q;

    assign w_proto_err = r_active & (iq == r_prev_iq);
    // A repeated I inside a window both aborts it and opens a fresh one.
    assign w_open      = iq & (~r_active | w_proto_err);
    assign w_i_add     = iq & r_active & ~w_proto_err;
    assign w_q_step    = ~iq & r_active & ~w_proto_err;
    assign w_q_load    = w_q_step & (r_cnt == '0);
    assign w_q_add     = w_q_step & (r_cnt != '0);
    assign w_last      = (r_cnt == r_n - nw'(1));
    assign w_done      = w_q_step & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_prev_iq <= 1'b0;
            r_cnt     <= '0;
            r_n       <= '0;
            r_shift   <= '0;
            r_strobe  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_prev_iq <= iq;
            r_strobe  <= w_done;
            if (w_proto_err)
                r_err <= 1'b1;

            if (w_open) begin
                r_active <= 1'b1;
                r_cnt    <= '0;
                r_n      <= (decim == '0) ? nw'(1) : decim;
                r_shift  <= shift;
            end else if (w_proto_err) begin
                r_active <= 1'b0;
                r_cnt    <= '0;
            end else if (w_q_step) begin
                if (w_done) begin
                    r_active <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + nw'(1);
                end
            end
        end
    end

    iq_acc_lane #(.dw(dw), .ow(ow), .aw(aw)) u_lane_i (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_open),
        .i_add   (w_i_add),
        .i_clr   (w_proto_err),
        .i_cap   (w_done),
        .i_shift (r_shift),
        .i_din   (din),
        .o_word  (i_out),
        .o_sat   (w_sat_i)
    );

    iq_acc_lane #(.dw(dw), .ow(ow), .aw(aw)) u_lane_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_q_load),
        .i_add   (w_q_add),
        .i_clr   (w_proto_err),
        .i_cap   (w_done),
        .i_shift (r_shift),
        .i_din   (din),
        .o_word  (q_out),
        .o_sat   (w_sat_q)
    );

    assign strobe = r_strobe;
    assign sat    = w_sat_i | w_sat_q;
    assign err    = r_err;

endmodule

// File: tb/tb_iq_decim_acc.sv
module tb_iq_decim_acc;

    localparam int DW = 20;
    localparam int OW = 22;
    localparam int NW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 iq = 1'b0;
    logic signed [DW-1:0] din = '0;
    logic [NW-1:0]        decim = '0;
    logic [3:0]           shift = '0;
    logic signed [OW-1:0] i_out;
    logic signed [OW-1:0] q_out;
    logic                 strobe;
    logic                 sat;
    logic                 err;

    typedef struct {
        int ei;
        int eq;
        bit es;
        int tag;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iq_decim_acc #(.dw(DW), .ow(OW), .nw(NW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iq     (iq),
        .din    (din),
        .decim  (decim),
        .shift  (shift),
        .i_out  (i_out),
        .q_out  (q_out),
        .strobe (strobe),
        .sat    (sat),
        .err    (err)
    );

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic send(input bit s_iq, input int v);
        iq  = s_iq;
        din = DW'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input int vi, input int vq);
        send(1'b1, vi);
        send(1'b0, vq);
    endtask

    // Called right after the last Q of a window: strobe must appear in the
    // cycle following the edge that sampled it.
    task automatic expect_out(input int ei, input int eq, input bit es);
        exp_t e;
        e.ei  = ei;
        e.eq  = eq;
        e.es  = es;
        e.tag = cyc;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (strobe) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
            end else begin
                m_e = sb.pop_front();
                if (i_out == m_e.ei && q_out == m_e.eq && sat == m_e.es && cyc == m_e.tag)
                    n_pass++;
                else
                    $display("FAIL strobe_word: got i=%0d q=%0d sat=%0d cycle=%0d, expected i=%0d q=%0d sat=%0d cycle=%0d",
                             i_out, q_out, sat, cyc, m_e.ei, m_e.eq, m_e.es, m_e.tag);
            end
        end else if (sat) begin
            n_total++;
            $display("FAIL sat_without_strobe: got sat=1 at cycle %0d, expected 0", cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state
        #12;
        check("rst_i_out", i_out, 0);
        check("rst_q_out", q_out, 0);
        check("rst_strobe", strobe, 0);
        check("rst_sat", sat, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // Leading Q samples are discarded; constant input, N=4, shift=2
        decim = 8'd4;
        shift = 4'd2;
        send(1'b0, 777);
        send(1'b0, 777);
        for (int w = 0; w < 3; w++) begin
            for (int p = 0; p < 4; p++)
                pair(1000, -500);
            expect_out(1000, -500, 1'b0);
        end
        send(1'b0, 0);
        send(1'b0, 0);
        check("err_after_const", err, 0);

        // Truncation toward -inf: (3+4)>>>1=3, (-3-4)>>>1=-4
        decim = 8'd2;
        shift = 4'd1;
        pair(3, -3);
        pair(4, -4);
        expect_out(3, -4, 1'b0);

        // Full-scale positive and negative with N=255, shift=0
        decim = 8'd255;
        shift = 4'd0;
        for (int p = 0; p < 255; p++)
            pair(524287, 0);
        expect_out(2097151, 0, 1'b1);
        for (int p = 0; p < 255; p++)
            pair(-524288, -1);
        expect_out(-2097152, -255, 1'b1);
        send(1'b0, 0);
        send(1'b0, 0);
        send(1'b0, 0);
        check("hold_i_out", i_out, -2097152);
        check("hold_q_out", q_out, -255);
        check("hold_strobe", strobe, 0);

        // decim=0 and decim=1: every pair is its own window
        decim = 8'd0;
        for (int k = 0; k < 4; k++) begin
            pair(10 * k + 1, -(10 * k + 2));
            expect_out(10 * k + 1, -(10 * k + 2), 1'b0);
        end
        decim = 8'd1;
        for (int k = 4; k < 8; k++) begin
            pair(10 * k + 1, -(10 * k + 2));
            expect_out(10 * k + 1, -(10 * k + 2), 1'b0);
        end

        // decim 4->2 and shift 0->1 mid-window apply only to the next window
        decim = 8'd4;
        shift = 4'd0;
        pair(1, 2);
        pair(1, 2);
        decim = 8'd2;
        shift = 4'd1;
        pair(1, 2);
        pair(1, 2);
        expect_out(4, 8, 1'b0);
        pair(5, 6);
        pair(5, 6);
        expect_out(5, 6, 1'b0);
        send(1'b0, 0);
        send(1'b0, 0);
        check("err_before_proto", err, 0);

        // Repeated I aborts the window; the second I starts a new one
        decim = 8'd3;
        shift = 4'd0;
        pair(100, 200);
        send(1'b1, 100);
        send(1'b1, 7);
        send(1'b0, 1);
        pair(7, 1);
        pair(7, 1);
        expect_out(21, 3, 1'b0);
        check("err_set", err, 1);
        send(1'b0, 0);
        send(1'b0, 0);
        send(1'b0, 0);
        send(1'b0, 0);
        check("err_sticky", err, 1);
        drain("drain_main");

        // Asynchronous reset mid-window, between clock edges
        decim = 8'd2;
        pair(9, 9);
        send(1'b1, 9);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_i_out", i_out, 0);
        check("arst_q_out", q_out, 0);
        check("arst_err", err, 0);
        check("arst_strobe", strobe, 0);
        check("arst_sat", sat, 0);
        #2;
        rst_n = 1'b1;
        send(1'b0, 55);
        pair(3, 4);
        pair(3, 4);
        expect_out(6, 8, 1'b0);
        drain("drain_after_reset");
        check("err_after_reset", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
